// File: rtl/clkgen_8284_param.sv
// Parametrised 8284A-style clock generator: osc/clk/pclk/vclk dividers, RDY/AEN ready sync, reset sync.
// Optional macro TURBO_EN adds a `turbo` input selecting an alternate osc divisor/high pair.
module clkgen_8284_param #(
  parameter int OSC_DIV   = 7,
  parameter int OSC_HIGH  = 3,
  parameter int CLK_MULT  = 3,
  parameter int PCLK_DIV  = 2,
  parameter int VCLK_DIV  = 5,
  parameter int VCLK_HIGH = 2
`ifdef TURBO_EN
  ,
  parameter int OSC_DIV_TURBO  = 5,
  parameter int OSC_HIGH_TURBO = 2
`endif
) (
  input  logic fpga_clk,
  input  logic reset_n,
  input  logic res_n,
  input  logic rdy1,
  input  logic rdy2,
  input  logic aen1_n,
  input  logic aen2_n,
  input  logic async_n,
`ifdef TURBO_EN
  input  logic turbo,
`endif
  output logic osc,
  output logic clk,
  output logic pclk,
  output logic vclk,
  output logic clk_rise,
  output logic clk_fall,
  output logic ready,
  output logic reset
);

`ifdef TURBO_EN
  localparam int OSC_MAX = (OSC_DIV_TURBO > OSC_DIV) ? OSC_DIV_TURBO : OSC_DIV;
`else
  localparam int OSC_MAX = OSC_DIV;
`endif
  localparam int OW = $clog2(OSC_MAX);
  localparam int CW = (CLK_MULT > 1) ? $clog2(CLK_MULT) : 1;
  localparam int PW = $clog2(PCLK_DIV);
  localparam int VW = $clog2(VCLK_DIV + 1);

  localparam logic [OW-1:0] OSC_LAST  = OW'(OSC_DIV - 1);
  localparam logic [OW-1:0] OSC_HI    = OW'(OSC_HIGH);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_MULT - 1);
  localparam logic [PW-1:0] PCLK_LAST = PW'(PCLK_DIV - 1);
  localparam logic [PW-1:0] PCLK_HALF = PW'(PCLK_DIV / 2);
  localparam logic [VW-1:0] VCLK_LAST = VW'(VCLK_DIV - 1);
  localparam logic [VW-1:0] VCLK_HI   = VW'(VCLK_HIGH);

  logic [OW-1:0] osc_cnt_q, osc_cnt_d;
  logic [CW-1:0] clk_ph_q, clk_ph_d;
  logic [PW-1:0] pclk_cnt_q, pclk_cnt_d;
  logic [VW-1:0] vclk_cnt_q, vclk_cnt_d;

  logic osc_q, osc_d;
  logic clk_q, clk_d;
  logic pclk_q, pclk_d;
  logic vclk_q, vclk_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic ready_q, ready_d;
  logic reset_q, reset_d;
  logic q1_q, q1_d;
  logic res_q, res_d;
  logic run_q, run_d;
  logic armed_q, armed_d;

  logic [OW-1:0] osc_last;
  logic [OW-1:0] osc_hi;
  logic          osc_wrap;
  logic          clk_wrap;
  logic          rise_ev;
  logic          fall_ev;
  logic          rdy_in;

  assign osc_wrap = (osc_cnt_q == osc_last);
  assign clk_wrap = (clk_ph_q == CLK_LAST);

`ifdef TURBO_EN
  localparam logic [OW-1:0] OSC_LAST_T = OW'(OSC_DIV_TURBO - 1);
  localparam logic [OW-1:0] OSC_HI_T   = OW'(OSC_HIGH_TURBO);

  logic turbo_q, turbo_d;

  // Divisor only switches at a full clk period boundary, so clk never gets a runt pulse.
  assign turbo_d  = (osc_wrap && clk_wrap) ? turbo : turbo_q;
  assign osc_last = turbo_q ? OSC_LAST_T : OSC_LAST;
  assign osc_hi   = turbo_q ? OSC_HI_T : OSC_HI;

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      turbo_q <= 1'b0;
    end else begin
      turbo_q <= turbo_d;
    end
  end
`else
  assign osc_last = OSC_LAST;
  assign osc_hi   = OSC_HI;
`endif

  always_comb begin
    osc_cnt_d  = osc_wrap ? '0 : osc_cnt_q + 1'b1;
    clk_ph_d   = clk_ph_q;
    pclk_cnt_d = pclk_cnt_q;
    vclk_cnt_d = (vclk_cnt_q == VCLK_LAST) ? '0 : vclk_cnt_q + 1'b1;
    if (osc_wrap) begin
      clk_ph_d = clk_wrap ? '0 : clk_ph_q + 1'b1;
      if (clk_wrap) begin
        pclk_cnt_d = (pclk_cnt_q == PCLK_LAST) ? '0 : pclk_cnt_q + 1'b1;
      end
    end
  end

  // Waveforms are decoded from pre-edge counts, so they trail the counters by one cycle.
  always_comb begin
    osc_d  = (osc_cnt_q < osc_hi);
    clk_d  = (clk_ph_q == '0);
    pclk_d = (pclk_cnt_q < PCLK_HALF);
    vclk_d = (vclk_cnt_q < VCLK_HI);
  end

  always_comb begin
    rdy_in  = (rdy1 & ~aen1_n) | (rdy2 & ~aen2_n);
    // The 0->1 step straight out of reset is not a real clk rising edge.
    rise_ev = clk_d & ~clk_q & run_q;
    fall_ev = ~clk_d & clk_q;
    run_d   = 1'b1;
    rise_d  = rise_ev;
    fall_d  = fall_ev;
    q1_d    = q1_q;
    res_d   = res_q;
    armed_d = armed_q;
    ready_d = ready_q;
    reset_d = reset_q;
    if (rise_ev) begin
      q1_d    = rdy_in;
      res_d   = ~res_n;
      armed_d = 1'b1;
    end
    // A fall with no sampled rise behind it has nothing valid in q1/res_q yet.
    if (fall_ev && armed_q) begin
      ready_d = async_n ? rdy_in : (q1_q & rdy_in);
      reset_d = res_q;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      osc_cnt_q  <= '0;
      clk_ph_q   <= '0;
      pclk_cnt_q <= '0;
      vclk_cnt_q <= '0;
      osc_q      <= 1'b0;
      clk_q      <= 1'b0;
      pclk_q     <= 1'b0;
      vclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      ready_q    <= 1'b0;
      reset_q    <= 1'b1;
      q1_q       <= 1'b0;
      res_q      <= 1'b0;
      run_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      osc_cnt_q  <= osc_cnt_d;
      clk_ph_q   <= clk_ph_d;
      pclk_cnt_q <= pclk_cnt_d;
      vclk_cnt_q <= vclk_cnt_d;
      osc_q      <= osc_d;
      clk_q      <= clk_d;
      pclk_q     <= pclk_d;
      vclk_q     <= vclk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      ready_q    <= ready_d;
      reset_q    <= reset_d;
      q1_q       <= q1_d;
      res_q      <= res_d;
      run_q      <= run_d;
      armed_q    <= armed_d;
    end
  end

  assign osc      = osc_q;
  assign clk      = clk_q;
  assign pclk     = pclk_q;
  assign vclk     = vclk_q;
  assign clk_rise = rise_q;
  assign clk_fall = fall_q;
  assign ready    = ready_q;
  assign reset    = reset_q;

endmodule

// File: tb/tb_clkgen_8284_param.sv
// Bench for clkgen_8284_param: default-parameter instance plus a 4/2/2/4 instance,
// both checked every cycle against a period/phase arithmetic model.
module tb_clkgen_8284_param;

  logic fpga_clk = 1'b0;
  logic reset_n, reset_n_b, res_n, rdy1, rdy2, aen1_n, aen2_n, async_n;
  logic osc_a, clk_a, pclk_a, vclk_a, rise_a, fall_a, ready_a, reset_a;
  logic osc_b, clk_b, pclk_b, vclk_b, rise_b, fall_b, ready_b, reset_b;

  int tests = 0;
  int fails = 0;

  // Model configuration: [0] = default instance, [1] = small-ratio instance.
  int od [2] = '{7, 4};
  int oh [2] = '{3, 2};
  int cm [2] = '{3, 2};
  int pd [2] = '{2, 4};

  int   m_n     [2];
  bit   m_q1    [2];
  bit   m_res   [2];
  bit   m_armed [2];
  bit   m_ready [2];
  bit   m_rst   [2];
  logic [7:0] exp_v [2];

  always #5 fpga_clk = ~fpga_clk;

  clkgen_8284_param dut_a (
    .fpga_clk(fpga_clk), .reset_n(reset_n), .res_n(res_n),
    .rdy1(rdy1), .rdy2(rdy2), .aen1_n(aen1_n), .aen2_n(aen2_n), .async_n(async_n),
`ifdef TURBO_EN
    .turbo(1'b0),
`endif
    .osc(osc_a), .clk(clk_a), .pclk(pclk_a), .vclk(vclk_a),
    .clk_rise(rise_a), .clk_fall(fall_a), .ready(ready_a), .reset(reset_a)
  );

  clkgen_8284_param #(.OSC_DIV(4), .OSC_HIGH(2), .CLK_MULT(2), .PCLK_DIV(4)) dut_b (
    .fpga_clk(fpga_clk), .reset_n(reset_n_b), .res_n(res_n),
    .rdy1(rdy1), .rdy2(rdy2), .aen1_n(aen1_n), .aen2_n(aen2_n), .async_n(async_n),
`ifdef TURBO_EN
    .turbo(1'b0),
`endif
    .osc(osc_b), .clk(clk_b), .pclk(pclk_b), .vclk(vclk_b),
    .clk_rise(rise_b), .clk_fall(fall_b), .ready(ready_b), .reset(reset_b)
  );

  function automatic string sig_name(input int b);
    case (b)
      7: return "osc";
      6: return "clk";
      5: return "pclk";
      4: return "vclk";
      3: return "clk_rise";
      2: return "clk_fall";
      1: return "ready";
      default: return "reset";
    endcase
  endfunction

  // Expected outputs after one edge, from the edge index since release and the period arithmetic.
  task automatic model_edge(input int i, input bit rst_n, input bit rin, input bit asn, input bit resn);
    int  p, ph;
    bit  rise, fall;
    if (!rst_n) begin
      m_n[i] = 0; m_q1[i] = 0; m_res[i] = 0; m_armed[i] = 0; m_ready[i] = 0; m_rst[i] = 1;
      exp_v[i] = 8'b0000_0001;
    end else begin
      m_n[i] = m_n[i] + 1;
      p    = od[i] * cm[i];
      ph   = (m_n[i] - 1) % p;
      rise = (m_n[i] > 1) && (ph == 0);
      fall = (ph == od[i]);
      if (fall && m_armed[i]) begin
        m_ready[i] = asn ? rin : (m_q1[i] & rin);
        m_rst[i]   = m_res[i];
      end
      if (rise) begin
        m_q1[i]    = rin;
        m_res[i]   = ~resn;
        m_armed[i] = 1;
      end
      exp_v[i] = {(((m_n[i] - 1) % od[i]) < oh[i]), (ph < od[i]),
                  (((m_n[i] - 1) % (p * pd[i])) < (p * pd[i] / 2)),
                  (((m_n[i] - 1) % 5) < 2), rise, fall, m_ready[i], m_rst[i]};
    end
  endtask

  task automatic check_all(input int i, input logic [7:0] obs);
    for (int b = 7; b >= 0; b--) begin
      tests++;
      assert (obs[b] === exp_v[i][b]) else begin
        fails++;
        $error("FAIL %s.%s edge=%0d observed=%b expected=%b",
               (i == 0) ? "dut_a" : "dut_b", sig_name(b), m_n[i], obs[b], exp_v[i][b]);
      end
    end
  endtask

  task automatic step();
    bit rin, ra, rb, asn, resn;
    rin  = (rdy1 & ~aen1_n) | (rdy2 & ~aen2_n);
    ra   = reset_n;
    rb   = reset_n_b;
    asn  = async_n;
    resn = res_n;
    @(posedge fpga_clk);
    #1;
    model_edge(0, ra, rin, asn, resn);
    model_edge(1, rb, rin, asn, resn);
    check_all(0, {osc_a, clk_a, pclk_a, vclk_a, rise_a, fall_a, ready_a, reset_a});
    check_all(1, {osc_b, clk_b, pclk_b, vclk_b, rise_b, fall_b, ready_b, reset_b});
  endtask

  task automatic step_n(input int k);
    for (int s = 0; s < k; s++) step();
  endtask

  task automatic restart(input int cycles);
    reset_n = 1'b0; reset_n_b = 1'b0;
    step_n(cycles);
    reset_n = 1'b1; reset_n_b = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; reset_n_b = 1'b0; res_n = 1'b1;
    rdy1 = 1'b0; rdy2 = 1'b0; aen1_n = 1'b1; aen2_n = 1'b1; async_n = 1'b0;

    // Reset held 3 cycles, then waveform/strobe/ready/reset sequence.
    step_n(3);
    reset_n = 1'b1; reset_n_b = 1'b1;
    step_n(10);
    res_n = 1'b0;
    step_n(6);
    reset_n_b = 1'b0;          // pulse small-ratio instance at edge 17
    step();
    reset_n_b = 1'b1;
    step_n(3);
    res_n = 1'b1; rdy1 = 1'b1; aen1_n = 1'b0; async_n = 1'b0;
    step_n(22);
    rdy1 = 1'b0;
    step_n(18);
    $display("[TB] phase 1 done at edge %0d", m_n[0]);

    // Two-stage ready on rdy2 first applied after edge 23.
    restart(2);
    rdy2 = 1'b0; aen2_n = 1'b1; async_n = 1'b0;
    step_n(23);
    rdy2 = 1'b1; aen2_n = 1'b0;
    step_n(32);
    $display("[TB] two-stage ready at edge 55: %b", ready_a);

    // One-stage ready, same stimulus.
    restart(2);
    rdy2 = 1'b0; aen2_n = 1'b1; async_n = 1'b1;
    step_n(23);
    rdy2 = 1'b1; aen2_n = 1'b0;
    step_n(12);
    $display("[TB] one-stage ready at edge 35: %b", ready_a);

    // Unqualified request must never reach ready.
    restart(2);
    rdy1 = 1'b1; aen1_n = 1'b1; rdy2 = 1'b0; aen2_n = 1'b1; async_n = 1'b0;
    step_n(200);
    $display("[TB] unqualified ready after 200 cycles: %b", ready_a);

    // Randomised inputs with occasional mid-period resets.
    for (int r = 0; r < 1500; r++) begin
      if ($urandom_range(0, 15) == 0) rdy1 = 1'($urandom);
      if ($urandom_range(0, 15) == 0) rdy2 = 1'($urandom);
      if ($urandom_range(0, 15) == 0) aen1_n = 1'($urandom);
      if ($urandom_range(0, 15) == 0) aen2_n = 1'($urandom);
      if ($urandom_range(0, 63) == 0) async_n = 1'($urandom);
      if ($urandom_range(0, 31) == 0) res_n = 1'($urandom);
      reset_n   = ($urandom_range(0, 249) != 0);
      reset_n_b = ($urandom_range(0, 249) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
